// File: rtl/plab2_proc_alu_arb.sv
// plab2_proc_alu_arb: two-client arbiter sequencing one shared combinational ALU,
// one operation in flight, with optional scrubbing of secure-domain state.
module plab2_proc_alu_arb #(
    parameter int p_nbits = 32,
    parameter bit p_scrub = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [3:0]         req0_fn,
    input  logic [p_nbits-1:0] req0_a,
    input  logic [p_nbits-1:0] req0_b,
    input  logic               req0_domain,
    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [3:0]         req1_fn,
    input  logic [p_nbits-1:0] req1_a,
    input  logic [p_nbits-1:0] req1_b,
    input  logic               req1_domain,
    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [p_nbits-1:0] resp0_data,
    output logic               resp0_err,
    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [p_nbits-1:0] resp1_data,
    output logic               resp1_err,
    output logic [3:0]         alu_fn,
    output logic [p_nbits-1:0] alu_in0,
    output logic [p_nbits-1:0] alu_in1,
    output logic               alu_domain,
    input  logic [p_nbits-1:0] alu_out,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_next;
    logic ptr, owner, domain, err, idle, g1, fire, resp_rdy, done;
    logic [3:0] fn;
    logic [p_nbits-1:0] a, b, result;

    // g1: client 1 wins when it is the lone requester or the pointer favours it
    always_comb begin
        idle = reset && state == IDLE;
        g1 = req1_val && (!req0_val || ptr);
        req0_rdy = idle && req0_val && !g1;
        req1_rdy = idle && g1;
        fire = req0_rdy || req1_rdy;
        resp_rdy = owner ? resp1_rdy : resp0_rdy;
        done = state == RESP && resp_rdy;
        state_next = state == IDLE ? (fire ? EXEC : IDLE) :
                     state == EXEC ? RESP : (resp_rdy ? IDLE : RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            domain <= 1'b0;
            err    <= 1'b0;
            fn     <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (fire) begin
                fn     <= g1 ? req1_fn : req0_fn;
                a      <= g1 ? req1_a : req0_a;
                b      <= g1 ? req1_b : req0_b;
                domain <= g1 ? req1_domain : req0_domain;
                owner  <= g1;
                ptr    <= !g1;
            end
            if (state == EXEC) begin
                result <= fn > 4'd12 ? '0 : alu_out;
                err    <= fn > 4'd12;
            end
            if (done && p_scrub && domain) begin
                fn     <= '0;
                a      <= '0;
                b      <= '0;
                result <= '0;
            end
        end
    end

    assign resp0_val  = reset && state == RESP && !owner;
    assign resp1_val  = reset && state == RESP && owner;
    assign resp0_data = result;
    assign resp1_data = result;
    assign resp0_err  = err;
    assign resp1_err  = err;
    assign alu_fn     = fn;
    assign alu_in0    = a;
    assign alu_in1    = b;
    assign alu_domain = domain;
    assign busy       = state != IDLE;
endmodule
